// File: rtl/bs_frame_ctrl.sv
// SPI frame controller: parses A5/opcode/20-byte payload/XOR frames, launches the
// pricing core, then streams the 32-bit result back MSB-first with sticky error flags.
module bs_frame_ctrl #(
    parameter int GAP_CYC  = 4096,
    parameter int CORE_TMO = 65536
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         cs_active,
    output logic         core_start,
    output logic [7:0]   core_opcode,
    output logic [159:0] core_params,
    input  logic         core_done,
    input  logic [31:0]  core_result,
    output logic [7:0]   tx_byte,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         err_proto,
    output logic         err_chk,
    output logic         err_tmo,
    input  logic         clr_err
);

    localparam int TMAX = (GAP_CYC > CORE_TMO) ? GAP_CYC : CORE_TMO;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(CORE_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_PAYLOAD, S_CHECK, S_LAUNCH, S_WAIT, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [7:0]     chk_q, chk_d;
    logic [7:0]     opc_q, opc_d;
    logic [159:0]   shadow_q, shadow_d;
    logic [31:0]    res_q, res_d;
    logic [159:0]   params_q, params_d;
    logic [7:0]     opcode_q, opcode_d;
    logic           start_q, start_d;
    logic [2:0]     err_q, err_d, set_err;   // [0] proto, [1] chk, [2] tmo

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        chk_d    = chk_q;
        opc_d    = opc_q;
        shadow_d = shadow_q;
        res_d    = res_q;
        params_d = params_q;
        opcode_d = opcode_q;
        start_d  = 1'b0;
        set_err  = 3'b000;

        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (rx_valid && rx_byte == 8'hA5) state_d = S_OPC;
            end
            S_OPC, S_PAYLOAD, S_CHECK: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    tmr_d = '0;
                    if (state_q == S_OPC) begin
                        if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                            opc_d   = rx_byte;
                            chk_d   = rx_byte;
                            cnt_d   = '0;
                            state_d = S_PAYLOAD;
                        end else begin
                            set_err[0] = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        // Shifting in from the bottom leaves byte i at [159-8i -: 8] after 20 bytes.
                        shadow_d = {shadow_q[151:0], rx_byte};
                        chk_d    = chk_q ^ rx_byte;
                        cnt_d    = cnt_q + 5'd1;
                        if (cnt_q == 5'd19) state_d = S_CHECK;
                    end else if (rx_byte == chk_q) begin
                        params_d = shadow_q;
                        opcode_d = opc_q;
                        state_d  = S_LAUNCH;
                    end else begin
                        set_err[1] = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (tmr_q == GAP_LAST) begin
                    set_err[2] = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_LAUNCH: begin
                start_d = 1'b1;
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    res_d   = core_result;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (tmr_q == TMO_LAST) begin
                    set_err[2] = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RESP: begin
                if (tx_ready) begin
                    res_d = {res_q[23:0], 8'h00};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd3) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Set dominates a coincident clear.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_err
            assign err_d[gi] = set_err[gi] | (err_q[gi] & ~clr_err);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            chk_q    <= '0;
            opc_q    <= '0;
            shadow_q <= '0;
            res_q    <= '0;
            params_q <= '0;
            opcode_q <= '0;
            start_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            chk_q    <= chk_d;
            opc_q    <= opc_d;
            shadow_q <= shadow_d;
            res_q    <= res_d;
            params_q <= params_d;
            opcode_q <= opcode_d;
            start_q  <= start_d;
            err_q    <= err_d;
        end
    end

    assign core_start  = start_q;
    assign core_opcode = opcode_q;
    assign core_params = params_q;
    assign tx_byte     = res_q[31:24];
    assign tx_valid    = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign err_proto   = err_q[0];
    assign err_chk     = err_q[1];
    assign err_tmo     = err_q[2];

endmodule

// File: tb/tb_bs_frame_ctrl.sv
// Randomised scoreboard bench for bs_frame_ctrl: stimulus pushes expected launches and
// response bytes, an independent monitor pops and compares them as the DUT presents them.
module tb_bs_frame_ctrl;

    localparam int GAP = 64;
    localparam int TMO = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         cs_active;
    logic         core_start;
    logic [7:0]   core_opcode;
    logic [159:0] core_params;
    logic         core_done;
    logic [31:0]  core_result;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         err_proto, err_chk, err_tmo;
    logic         clr_err;

    typedef struct {
        logic [7:0]   op;
        logic [159:0] prm;
        int           cyc;
    } launch_t;

    launch_t      exp_launch_q[$];
    logic [7:0]   exp_tx_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           core_mode = 0;      // 0 normal, 1 late reply (ignored), 2 no reply
    int           tx_mode = 0;        // 0 random ready, 1 held low, 2 held high
    bit           fixed_res_en = 1'b0;
    logic [31:0]  fixed_res = 32'h0;
    logic [159:0] model_params = '0;
    logic [7:0]   model_op = '0;

    bs_frame_ctrl #(.GAP_CYC(GAP), .CORE_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .cs_active(cs_active), .core_start(core_start), .core_opcode(core_opcode),
        .core_params(core_params), .core_done(core_done), .core_result(core_result),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .err_proto(err_proto), .err_chk(err_chk), .err_tmo(err_tmo), .clr_err(clr_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_event(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen, required none (cycle %0d)", name, cyc);
    endtask

    // Transmit-side ready generator.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                1:       tx_ready = 1'b0;
                2:       tx_ready = 1'b1;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Pricing-core model: answers each core_start and predicts the four response bytes.
    initial begin
        int mode;
        int dly;
        logic [31:0] res;
        core_done = 1'b0;
        core_result = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && core_start && core_mode != 2) begin
                mode = core_mode;
                dly = (mode == 1) ? 30 : int'($urandom_range(1, 12));
                repeat (dly) @(posedge clk);
                #1;
                res = fixed_res_en ? fixed_res : $urandom;
                core_result = res;
                core_done = 1'b1;
                if (mode == 0)
                    for (int i = 0; i < 4; i++) exp_tx_q.push_back(res[31-8*i -: 8]);
                @(posedge clk); #1;
                core_done = 1'b0;
                core_result = $urandom;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT launches or transfers a byte.
    initial begin
        launch_t e;
        logic [7:0] b;
        bit hold_prev;
        logic [7:0] hold_byte;
        hold_prev = 1'b0;
        hold_byte = 8'h0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (core_start) begin
                    if (exp_launch_q.size() == 0) flag_event("unexpected core_start");
                    else begin
                        e = exp_launch_q.pop_front();
                        check("launch opcode", 160'(core_opcode), 160'(e.op));
                        check("launch params", core_params, e.prm);
                        check("launch latency cycle", 160'(cyc), 160'(e.cyc));
                    end
                end
                if (hold_prev) begin
                    check("tx_valid held", 160'(tx_valid), 160'(1));
                    check("tx_byte held", 160'(tx_byte), 160'(hold_byte));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx_q.size() == 0) flag_event("unexpected tx transfer");
                    else begin
                        b = exp_tx_q.pop_front();
                        check("tx byte", 160'(tx_byte), 160'(b));
                    end
                end
                hold_prev = tx_valid && !tx_ready;
                hold_byte = tx_byte;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    // Builds a frame from the byte-level rules; nbytes > 0 truncates it.
    task automatic send_frame(input logic [7:0] op, input logic [159:0] prm,
                              input bit corrupt, input int nbytes);
        logic [7:0] bq[$];
        logic [7:0] x;
        x = op;
        bq.push_back(8'hA5);
        bq.push_back(op);
        for (int i = 0; i < 20; i++) begin
            bq.push_back(prm[159-8*i -: 8]);
            x ^= prm[159-8*i -: 8];
        end
        bq.push_back(x ^ {7'd0, corrupt});
        if (nbytes > 0) while (bq.size() > nbytes) void'(bq.pop_back());
        @(posedge clk); #1;
        foreach (bq[i]) begin
            idle(int'($urandom_range(0, 3)));
            send_byte(bq[i]);
        end
        if (nbytes == 0 && !corrupt && (op == 8'h01 || op == 8'h02)) begin
            exp_launch_q.push_back('{op, prm, cyc + 1});
            model_params = prm;
            model_op = op;
        end
    endtask

    task automatic wait_idle(input int lim, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < lim) begin @(negedge clk); n++; end
        check(name, 160'(busy), 160'(0));
        check("launch queue drained", 160'(exp_launch_q.size()), 160'(0));
        check("tx queue drained", 160'(exp_tx_q.size()), 160'(0));
    endtask

    task automatic clear_errors();
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("flags after clr_err", 160'({err_proto, err_chk, err_tmo}), 160'(0));
    endtask

    task automatic end_frame(input bit ep, input bit ec, input bit et);
        check("err_proto", 160'(err_proto), 160'(ep));
        check("err_chk", 160'(err_chk), 160'(ec));
        check("err_tmo", 160'(err_tmo), 160'(et));
        check("core_params retained", core_params, model_params);
        check("core_opcode retained", 160'(core_opcode), 160'(model_op));
        clear_errors();
    endtask

    function automatic logic [159:0] rnd_params();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [159:0] DIR_PRM = {32'h00010000, 32'h00012000, 32'h00008000,
                                        32'h00000CCD, 32'h00003333};

    initial begin
        logic [159:0] p;
        logic [7:0] op;
        bit bad, corrupt;
        int n;
        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h0; cs_active = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 160'(busy), 160'(0));
        check("reset core_start", 160'(core_start), 160'(0));
        check("reset tx_valid", 160'(tx_valid), 160'(0));
        check("reset tx_byte", 160'(tx_byte), 160'(0));
        check("reset flags", 160'({err_proto, err_chk, err_tmo}), 160'(0));
        check("reset core_params", core_params, 160'(0));
        check("reset core_opcode", 160'(core_opcode), 160'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed call frame with a known result.
        fixed_res_en = 1'b1; fixed_res = 32'hDEADBEEF;
        send_frame(8'h01, DIR_PRM, 1'b0, 0);
        wait_idle(500, "idle after directed frame");
        end_frame(1'b0, 1'b0, 1'b0);

        // Same frame with corrupted checksum.
        send_frame(8'h01, DIR_PRM, 1'b1, 0);
        wait_idle(50, "idle after bad checksum");
        end_frame(1'b0, 1'b1, 1'b0);

        // Illegal opcode, then a good put frame.
        send_frame(8'h07, rnd_params(), 1'b0, 2);
        wait_idle(50, "idle after bad opcode");
        end_frame(1'b1, 1'b0, 1'b0);
        send_frame(8'h02, rnd_params(), 1'b0, 0);
        wait_idle(500, "idle after recovery frame");
        end_frame(1'b0, 1'b0, 1'b0);

        // Byte-gap timeout 10 bytes into payload, with clr_err coinciding with the set.
        send_frame(8'h01, rnd_params(), 1'b0, 12);
        repeat (GAP - 1) @(posedge clk);
        @(negedge clk);
        check("busy before gap expiry", 160'(busy), 160'(1));
        check("err_tmo before gap expiry", 160'(err_tmo), 160'(0));
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("busy after gap expiry", 160'(busy), 160'(0));
        end_frame(1'b0, 1'b0, 1'b1);

        // Chip-select drop at the same point aborts silently.
        send_frame(8'h02, rnd_params(), 1'b0, 12);
        cs_active = 1'b0;
        @(posedge clk); #1;
        cs_active = 1'b1;
        @(negedge clk);
        check("busy after cs drop", 160'(busy), 160'(0));
        end_frame(1'b0, 1'b0, 1'b0);

        // Transmit back-pressure for 50 cycles; rx noise and cs drop must be ignored.
        tx_mode = 1;
        send_frame(8'h01, rnd_params(), 1'b0, 0);
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 100) begin @(negedge clk); n++; end
        check("tx_valid rises", 160'(tx_valid), 160'(1));
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            rx_valid = (i == 10 || i == 20);
            rx_byte = 8'hA5;
            cs_active = !(i >= 30 && i < 40);
            @(negedge clk);
            check("stall tx_valid", 160'(tx_valid), 160'(1));
            check("stall tx_byte", 160'(tx_byte), 160'(8'hDE));
        end
        @(posedge clk); #1;
        rx_valid = 1'b0; cs_active = 1'b1; tx_mode = 0;
        wait_idle(500, "idle after stall");
        end_frame(1'b0, 1'b0, 1'b0);
        fixed_res_en = 1'b0;

        // Core never answers: timeout exactly CORE_TMO cycles after core_start.
        core_mode = 2;
        send_frame(8'h02, rnd_params(), 1'b0, 0);
        repeat (TMO) @(posedge clk);
        @(negedge clk);
        check("busy before core timeout", 160'(busy), 160'(1));
        check("err_tmo before core timeout", 160'(err_tmo), 160'(0));
        @(negedge clk);
        check("busy after core timeout", 160'(busy), 160'(0));
        end_frame(1'b0, 1'b0, 1'b1);

        // Reset while waiting on the core; the late core_done must be ignored.
        core_mode = 1;
        send_frame(8'h01, rnd_params(), 1'b0, 0);
        idle(5);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-wait reset busy", 160'(busy), 160'(0));
        check("mid-wait reset core_params", core_params, 160'(0));
        idle(2);
        rst_n = 1'b1;
        model_params = '0;
        model_op = '0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            check("post-reset tx_valid", 160'(tx_valid), 160'(0));
            check("post-reset busy", 160'(busy), 160'(0));
        end
        core_mode = 0;
        end_frame(1'b0, 1'b0, 1'b0);

        // Randomised frames.
        for (int k = 0; k < 30; k++) begin
            bad = ($urandom_range(0, 7) == 0);
            op = bad ? 8'(3 + $urandom_range(0, 100)) : ($urandom_range(0, 1) == 1 ? 8'h01 : 8'h02);
            corrupt = !bad && ($urandom_range(0, 5) == 0);
            p = rnd_params();
            send_frame(op, p, corrupt, bad ? 2 : 0);
            wait_idle(1000, "idle after random frame");
            end_frame(bad, corrupt, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
